fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the ID stage with IR/NPC pairs.
- Issues word-addressed reads to instruction memory and buffers in-order responses in a prefetch FIFO.
- Handles branch redirects from EX/MEM and stops fetching after the HLT opcode.
- Decouples instruction-memory latency from decode throughput.

---
 rtl/fetch_prefetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues in-order word reads to instruction memory,
// buffers responses in a credit-limited prefetch FIFO, and handles redirects and HLT.
module fetch_prefetch_unit #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 10,
  parameter logic [AW-1:0]   START_PC = '0,
  parameter logic [5:0]      HLT_OP   = 6'b111111
)(
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_ir,
  output logic [AW-1:0] inst_npc,
  output logic          halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]   ir;
    logic [AW-1:0] npc;
  } entry_t;

  entry_t [DEPTH-1:0]         fifo_q;
  logic   [DEPTH-1:0][AW-1:0] addr_q;
  logic   [PW-1:0]            rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic   [CW-1:0]            cnt, outst, drop, outst_nxt;
  logic   [AW-1:0]            pc;
  logic                       stop;

  logic   room, req_fire, redir, rsp_keep, rsp_drop, rsp_hlt, enq, deq;
  entry_t head;

  // Credits cover both buffered and in-flight words, so the FIFO cannot overflow.
  assign room      = ((CW+1)'(cnt) + (CW+1)'(outst)) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !stop && !halted && room;
  assign imem_req_addr  = pc;
  assign req_fire  = imem_req_valid && imem_req_ready;

  assign redir     = redirect_valid && !halted;
  assign rsp_drop  = imem_rsp_valid && (drop != '0);
  assign rsp_keep  = imem_rsp_valid && (drop == '0);
  assign rsp_hlt   = rsp_keep && (imem_rsp_data[31:26] == HLT_OP);
  assign enq       = rsp_keep && !redir;
  assign outst_nxt = outst + CW'(req_fire) - CW'(imem_rsp_valid);

  assign head       = fifo_q[rd_ptr];
  assign inst_valid = (cnt != '0);
  assign inst_ir    = head.ir;
  assign inst_npc   = head.npc;
  assign deq        = inst_valid && inst_ready;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc     <= START_PC;
      cnt    <= '0;
      outst  <= '0;
      drop   <= '0;
      stop   <= 1'b0;
      halted <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      aq_rd  <= '0;
      aq_wr  <= '0;
      fifo_q <= '0;
      addr_q <= '0;
    end else begin
      // Request addresses are tracked for every in-flight read, even ones to be dropped.
      if (req_fire) begin
        addr_q[aq_wr] <= pc;
        aq_wr         <= aq_wr + PW'(1);
      end
      if (imem_rsp_valid) aq_rd <= aq_rd + PW'(1);
      outst <= outst_nxt;

      if (deq && (head.ir[31:26] == HLT_OP)) halted <= 1'b1;

      if (redir) begin
        // Everything still in flight after this edge belongs to the old path.
        pc     <= redirect_pc;
        stop   <= 1'b0;
        drop   <= outst_nxt;
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire) pc <= pc + AW'(1);
        if (rsp_hlt) begin
          stop <= 1'b1;
          drop <= outst_nxt;
        end else if (rsp_drop) begin
          drop <= drop - CW'(1);
        end
        if (enq) begin
          fifo_q[wr_ptr] <= '{ir: imem_rsp_data, npc: addr_q[aq_rd] + AW'(1)};
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model with configurable latency and
// a scoreboard of IR/NPC pairs that decode should see, plus directed corner sequences.
module tb_fetch_prefetch_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid, inst_ready;
  logic [31:0]   inst_ir;
  logic [AW-1:0] inst_npc;
  logic          halted;

  always #5 clk1 = ~clk1;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .AW(AW), .START_PC('0), .HLT_OP(6'b111111)) dut (
    .clk1(clk1), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_ir(inst_ir), .inst_npc(inst_npc),
    .halted(halted)
  );

  typedef struct { logic [31:0] ir; logic [AW-1:0] npc; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } pend_t;
  typedef struct { logic rdy; logic v; logic [31:0] ir; logic [AW-1:0] npc; } vec_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] mem [0:1023];
  int total = 0, bad = 0;
  int cyc, lat, req_budget, reqs, pops, hi_reqs;
  logic [AW-1:0] exp_pc, s_req_addr, s_npc, first_pop_npc;
  logic [31:0]   s_ir, last_pop_ir, first_pop_ir;
  logic          hlt_seen, model_halted, s_req_valid, s_inst_valid, s_halted;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    exp_pc = '0; hlt_seen = 1'b0; model_halted = 1'b0;
    cyc = 0; reqs = 0; pops = 0; hi_reqs = 0; req_budget = 1000000;
  endtask

  // Called at a falling edge; leaves the bench at a falling edge with rst low.
  task automatic do_reset();
    rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #2;
    @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    clear_model();
  endtask

  // One clock cycle: drive memory, sample outputs, update scoreboard, advance.
  task automatic tick();
    pend_t p;
    exp_t  e;
    logic  fire, pop, halt_pend;
    halt_pend = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[p.addr];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = (req_budget > 0);
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_inst_valid = inst_valid; s_ir = inst_ir; s_npc = inst_npc; s_halted = halted;
    fire = s_req_valid && imem_req_ready;
    pop  = s_inst_valid && inst_ready;
    if (pop) begin
      if (exp_q.size() == 0) chk("sb_extra_inst", 64'(s_inst_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_ir", 64'(s_ir), 64'(e.ir));
        chk("sb_npc", 64'(s_npc), 64'(e.npc));
        if (pops == 0) begin first_pop_ir = s_ir; first_pop_npc = s_npc; end
        last_pop_ir = s_ir;
        pops++;
        if (e.ir[31:26] == 6'h3f) halt_pend = 1'b1;
      end
    end
    if (fire) begin
      chk("req_addr", 64'(s_req_addr), 64'(exp_pc));
      pend_q.push_back('{s_req_addr, cyc + lat});
      if (!hlt_seen) begin
        exp_q.push_back('{mem[exp_pc], AW'(exp_pc + 1)});
        if (mem[exp_pc][31:26] == 6'h3f) hlt_seen = 1'b1;
      end
      if (s_req_addr >= 10) hi_reqs++;
      req_budget--;
      reqs++;
    end
    if (redirect_valid && !model_halted) begin
      exp_q.delete();
      hlt_seen = 1'b0;
      exp_pc = redirect_pc;
    end else if (fire) begin
      exp_pc = AW'(exp_pc + 1);
    end
    chk("halted", 64'(s_halted), 64'(model_halted));
    @(posedge clk1);
    if (halt_pend) model_halted = 1'b1;
    @(negedge clk1);
    redirect_valid = 1'b0;
    cyc++;
  endtask

  vec_t vt[6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h2801000a; mem[1] = 32'h28020014;
    mem[2] = 32'h28030019; mem[3] = 32'h00222000;
    mem[8] = 32'hfc000000; mem[9] = 32'h00000000;

    vt[0] = '{1'b1, 1'b0, 32'h0,        10'd0};
    vt[1] = '{1'b1, 1'b0, 32'h0,        10'd0};
    vt[2] = '{1'b1, 1'b1, 32'h2801000a, 10'd1};
    vt[3] = '{1'b1, 1'b1, 32'h28020014, 10'd2};
    vt[4] = '{1'b1, 1'b1, 32'h28030019, 10'd3};
    vt[5] = '{1'b1, 1'b1, 32'h00222000, 10'd4};

    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    lat = 1;
    clear_model();
    rst = 1'b1;
    #3;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_ir", 64'(inst_ir), 64'd0);
    chk("rst_inst_npc", 64'(inst_npc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(negedge clk1);
    do_reset();

    // Streaming with 1-cycle memory
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      inst_ready = vt[i].rdy;
      tick();
      chk("tbl_valid", 64'(s_inst_valid), 64'(vt[i].v));
      if (vt[i].v) begin
        chk("tbl_ir", 64'(s_ir), 64'(vt[i].ir));
        chk("tbl_npc", 64'(s_npc), 64'(vt[i].npc));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_rate", 64'(s_inst_valid), 64'd1);
    end

    // Backpressure: decode stalls for 10 cycles
    do_reset();
    lat = 1; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_reqs", 64'(reqs), 64'(DEPTH));
    chk("bp_req_valid", 64'(s_req_valid), 64'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_drained", 64'(pops >= DEPTH), 64'd1);
    chk("bp_first", 64'(first_pop_ir), 64'h2801000a);

    // Redirect with one buffered entry and two reads in flight (3-cycle memory)
    do_reset();
    lat = 3; inst_ready = 1'b0; req_budget = 3;
    for (int i = 0; i < 4; i++) tick();
    req_budget = 1000000;
    redirect_valid = 1'b1; redirect_pc = 10'd9;
    tick();
    chk("redir_buffered", 64'(s_inst_valid), 64'd1);
    chk("redir_rsp_same_cycle", 64'(imem_rsp_valid), 64'd1);
    inst_ready = 1'b1;
    tick();
    chk("redir_flushed", 64'(s_inst_valid), 64'd0);
    for (int i = 0; i < 20 && pops == 0; i++) tick();
    chk("redir_seen", 64'(pops > 0), 64'd1);
    chk("redir_ir", 64'(first_pop_ir), 64'h0);
    chk("redir_npc", 64'(first_pop_npc), 64'd10);

    // HLT at address 8 ends fetching
    do_reset();
    lat = 1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 10'd8;
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk("hlt_no_high_reqs", 64'(hi_reqs), 64'd0);
    chk("hlt_only_one", 64'(pops), 64'd1);
    chk("hlt_word", 64'(last_pop_ir), 64'hfc000000);
    chk("hlt_halted", 64'(s_halted), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 10'd2;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("hlt_redir_ignored_req", 64'(s_req_valid), 64'd0);
    chk("hlt_redir_ignored_inst", 64'(s_inst_valid), 64'd0);
    chk("hlt_redir_ignored_pops", 64'(pops), 64'd1);

    // Redirect squashes an unconsumed HLT
    do_reset();
    lat = 1; inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 10'd8;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("sq_hlt_buffered", 64'(s_inst_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 10'd2;
    tick();
    inst_ready = 1'b1; pops = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("sq_first_ir", 64'(first_pop_ir), 64'h28030019);
    chk("sq_first_npc", 64'(first_pop_npc), 64'd3);
    chk("sq_not_halted", 64'(s_halted), 64'd0);

    // Asynchronous reset between clock edges
    do_reset();
    lat = 1; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("ar_pre_valid", 64'(s_inst_valid), 64'd1);
    #2;
    rst = 1'b1; imem_rsp_valid = 1'b0;
    #1;
    chk("ar_inst_valid", 64'(inst_valid), 64'd0);
    chk("ar_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    clear_model();
    tick();
    chk("ar_restart_valid", 64'(s_req_valid), 64'd1);
    chk("ar_restart_addr", 64'(s_req_addr), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("ar_restart_stream", 64'(first_pop_ir), 64'h2801000a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
